// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Receives a length-prefixed little-endian byte stream, writes the image into
// instruction memory from word 0 upward, then releases the core and serves
// fetches from the same memory.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, RUN, ERR} state_t;

  localparam logic [16:0]     MAX_N = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [7:0]        nlo_reg;
  logic [ADDR_W:0]   nwords_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       shift_reg;
  logic [ADDR_W:0]   asm_cnt_reg;
  logic              we_reg;
  logic [31:0]       wdata_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [ADDR_W:0]   loaded_reg;

  logic              xfer;
  logic [15:0]       hdr_n;
  logic              word_end;
  logic              last_byte;
  logic              unused_pc_bits;

  assign xfer      = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, nlo_reg};
  assign word_end  = (state_reg == DATA) && xfer && (byte_cnt_reg == 2'd3);
  assign last_byte = word_end && ((asm_cnt_reg + ONE) == nwords_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= HDR0;
    else     state_reg <= state_next;
  end

  // Next-state logic: header parse, data phase, terminal RUN/ERR.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR0: if (xfer) state_next = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr_n == 16'd0)               state_next = RUN;
          else if ({1'b0, hdr_n} > MAX_N)   state_next = ERR;
          else                              state_next = DATA;
        end
      end
      DATA:    if (last_byte) state_next = RUN;
      RUN:     state_next = RUN;
      ERR:     state_next = ERR;
      default: state_next = HDR0;
    endcase
  end

  // Datapath: header latch, word assembly, one-cycle write pulse, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      nlo_reg      <= '0;
      nwords_reg   <= '0;
      byte_cnt_reg <= '0;
      shift_reg    <= '0;
      asm_cnt_reg  <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      waddr_reg    <= '0;
      loaded_reg   <= '0;
    end else begin
      we_reg <= 1'b0;
      // The word index advances once the write it addressed has been issued.
      if (we_reg) waddr_reg <= waddr_reg + 1'b1;
      if (state_reg == HDR0 && xfer) nlo_reg <= rx_data;
      // Only counts up to 2**ADDR_W reach DATA, so truncation is lossless there.
      if (state_reg == HDR1 && xfer) nwords_reg <= (ADDR_W+1)'(hdr_n);
      if (state_reg == DATA && xfer) begin
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        // First byte of each word ends up in bits [7:0].
        shift_reg    <= {rx_data, shift_reg[23:8]};
      end
      if (word_end) begin
        wdata_reg   <= {rx_data, shift_reg};
        we_reg      <= 1'b1;
        asm_cnt_reg <= asm_cnt_reg + ONE;
        loaded_reg  <= loaded_reg + ONE;
      end
    end
  end

  assign rx_ready     = !rst && (state_reg == HDR0 || state_reg == HDR1 || state_reg == DATA);
  assign mem_we       = we_reg && !rst;
  assign mem_waddr    = waddr_reg;
  assign mem_wdata    = wdata_reg;
  assign core_run     = !rst && (state_reg == RUN);
  assign load_done    = core_run;
  assign load_err     = !rst && (state_reg == ERR);
  assign words_loaded = loaded_reg;
  assign mem_raddr    = pc[ADDR_W+1:2];
  assign instr        = core_run ? mem_rdata : 32'h0;
  assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of the boot loader with a write scoreboard
// and a behavioural instruction memory.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [31:0]       pc;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  logic [31:0] tb_mem [0:(2**ADDR_W)-1];
  logic [63:0] exp_q [$];
  logic [31:0] words [0:2];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .pc(pc), .instr(instr), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .core_run(core_run), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  // Behavioural instruction memory: combinational read, clocked write.
  assign mem_rdata = tb_mem[mem_raddr];
  always @(posedge clk) if (mem_we) tb_mem[mem_waddr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {31'b0, mem_we}, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        $display("write addr=%0d data=%h words_loaded=%0d", mem_waddr, mem_wdata, words_loaded);
        chk("waddr", {22'b0, mem_waddr}, e[63:32]);
        chk("wdata", mem_wdata, e[31:0]);
        chk("words_loaded_at_we", {21'b0, words_loaded}, e[63:32] + 32'd1);
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 2**ADDR_W; i++) tb_mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    chk("rx_ready_in_rst", {31'b0, rx_ready}, 32'd0);
    chk("core_run_in_rst", {31'b0, core_run}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_core_run", {31'b0, core_run}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    chk("rst_words_loaded", {21'b0, words_loaded}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    $display("reset done");
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_valid = 1'b1; rx_data = b;
    #1;
    chk("rx_ready_offer", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input bit gap);
    exp_q.push_back({idx[31:0], w});
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic check_fetch(input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    #1;
    $display("fetch pc=%h instr=%h", pc, instr);
    chk("fetch", instr, exp);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pc = 32'h0;
    clear_mem();
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678; words[2] = 32'hA5C3_0F81;

    // Test-plan image: N=2.
    do_reset();
    send_hdr(16'd2);
    send_word(0, 32'h0062E233, 1'b0);
    send_word(1, 32'h00B62423, 1'b0);
    chk("t1_last_we", {31'b0, mem_we}, 32'd1);
    chk("t1_core_run", {31'b0, core_run}, 32'd1);
    chk("t1_load_done", {31'b0, load_done}, 32'd1);
    chk("t1_words_loaded", {21'b0, words_loaded}, 32'd2);
    rx_valid = 1'b0;
    @(negedge clk);
    check_fetch(32'd4, 32'h00B62423);
    check_fetch(32'd0, 32'h0062E233);

    // Back-to-back N=3, then the same image with rx_valid toggling.
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      do_reset();
      send_hdr(16'd3);
      for (int i = 0; i < 3; i++) send_word(i, words[i], pass[0]);
      rx_valid = 1'b0;
      @(negedge clk);
      chk("t2_core_run", {31'b0, core_run}, 32'd1);
      chk("t2_words_loaded", {21'b0, words_loaded}, 32'd3);
      for (int i = 0; i < 3; i++) check_fetch(i * 4, words[i]);
    end

    // Oversized header N=1025.
    do_reset();
    send_hdr(16'h0401);
    chk("t3_load_err", {31'b0, load_err}, 32'd1);
    chk("t3_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("t3_core_run", {31'b0, core_run}, 32'd0);
    chk("t3_mem_we", {31'b0, mem_we}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", {31'b0, load_err}, 32'd1);
    chk("t3_instr", instr, 32'd0);
    rx_valid = 1'b0;

    // Empty image N=0.
    do_reset();
    send_hdr(16'd0);
    chk("t4_core_run", {31'b0, core_run}, 32'd1);
    chk("t4_words_loaded", {21'b0, words_loaded}, 32'd0);
    chk("t4_mem_we", {31'b0, mem_we}, 32'd0);
    rx_valid = 1'b0;

    // Reset after 6 data bytes of N=3, then a fresh N=1 load.
    do_reset();
    send_hdr(16'd3);
    send_word(0, 32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_words_loaded", {21'b0, words_loaded}, 32'd0);
    chk("t5_core_run", {31'b0, core_run}, 32'd0);
    chk("t5_rx_ready", {31'b0, rx_ready}, 32'd1);
    @(negedge clk);
    send_hdr(16'd1);
    send_word(0, 32'hCAFEF00D, 1'b0);
    rx_valid = 1'b0;
    chk("t5_core_run_after", {31'b0, core_run}, 32'd1);
    chk("t5_words_after", {21'b0, words_loaded}, 32'd1);
    @(negedge clk);
    check_fetch(32'h0000_1000, 32'hCAFEF00D);
    check_fetch(32'h0000_0003, 32'hCAFEF00D);

    // Bytes offered in RUN are refused and ignored.
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'hF0 + i);
      #1;
      chk("t6_rx_ready", {31'b0, rx_ready}, 32'd0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("t6_words_loaded", {21'b0, words_loaded}, 32'd1);
    check_fetch(32'h0, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller for the single-cycle core's instruction memory. Holds the core in reset and accepts a length-prefixed byte stream through a valid/ready port. Assembles little-endian 32-bit words and writes them into the instruction memory array from word 0 upward. Once the image is complete, it releases the core and serves fetch reads from the same array.

## Interface
- `ADDR_W`, default 10: word-address width; memory depth is `2**ADDR_W` words (1024).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: byte available on `rx_data`.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader can accept a byte.
- `pc` in 32: core fetch address (byte address).
- `instr` out 32: fetched instruction to the core.
- `mem_raddr` out ADDR_W: memory read word address.
- `mem_rdata` in 32: memory read data (combinational read).
- `mem_we` out 1: memory write strobe.
- `mem_waddr` out ADDR_W: memory write word address.
- `mem_wdata` out 32: memory write data.
- `core_run` out 1: high releases the core from reset.
- `load_done` out 1: image loaded, sticky until `rst`.
- `load_err` out 1: header error, sticky until `rst`.
- `words_loaded` out ADDR_W+1: count of words written so far.

## Operation
- Stream format:
  - Bytes 0-1 are word count N, 16-bit little-endian.
  - Then exactly 4·N bytes follow, each word little-endian (first byte goes to bits [7:0]).
- A byte transfers on a cycle where `rx_valid && rx_ready`.
- States: HDR0 (after reset), HDR1, DATA, RUN, ERR.
- `rx_ready` = 1 in HDR0, HDR1 and DATA; 0 in RUN and ERR; forced 0 while `rst` = 1.
- State transitions:
  - HDR0 → HDR1 on transfer; the byte is latched as N[7:0].
  - HDR1 on transfer:
    - If {byte, N[7:0]} = 0 → RUN.
    - If {byte, N[7:0]} > `2**ADDR_W` → ERR.
    - Otherwise → DATA.
  - DATA: a 2-bit byte counter shifts bytes into a word register. On the 4th byte of a word, the assembled word is registered for writing and the counter wraps to 0. After the 4·N-th byte → RUN.
  - RUN and ERR are terminal until `rst`.
- Write port: `mem_we` pulses for one cycle, carrying the registered word at `mem_waddr` = current word index. The word index then increments. `words_loaded` increments in the same cycle `mem_we` is high.
- Fetch:
  - `mem_raddr` = `pc[ADDR_W+1:2]`, combinational in all states.
  - `pc[1:0]` and bits above ADDR_W+1 are ignored (address wraps).
  - `instr` = `mem_rdata` when `core_run` = 1, else 32'h0.
- `core_run` = `load_done` = 1 in RUN. `load_err` = 1 in ERR; `core_run` stays 0 in ERR.
- Reset mid-load: the FSM returns to HDR0, counters clear and `core_run` drops. Already-written memory contents are not cleared.
- Bytes offered in RUN or ERR are not accepted (`rx_ready` = 0) and have no effect.

## Timing
- Reset values (all outputs, while `rst` = 1 and the first cycle after):
  - `rx_ready` = 0 during `rst`, 1 the first cycle after it deasserts.
  - `mem_we` = 0, `core_run` = 0, `load_done` = 0, `load_err` = 0, `words_loaded` = 0, `instr` = 0.
- Byte throughput: one byte per cycle with no bubbles. A word's write (cycle after its 4th byte) overlaps acceptance of the next word's first byte.
- Write latency: `mem_we` is high in the cycle after the 4th byte's transfer edge.
- Run release:
  - `core_run` rises in the same cycle as the last `mem_we`, i.e. state is RUN in that cycle.
  - The write commits at the end of that cycle, so the core's first reset-released edge sees a complete image.
  - For N = 0, `core_run` rises the cycle after the HDR1 transfer.
- Fetch path is purely combinational (`pc` → `instr`); zero added latency.
- ERR is entered the cycle after the HDR1 transfer; `load_err` is high from that cycle.

## Test plan
- N = 2, bytes 02 00 | 33 E2 62 00 | 23 24 B6 00:
  - `mem_we` at word 0 with 32'h0062E233, then at word 1 with 32'h00B62423.
  - `words_loaded` = 2; `core_run` = `load_done` = 1.
  - `pc` = 4 gives `instr` = 32'h00B62423.
- Back-to-back stream with `rx_valid` held high: zero-stall acceptance. `rx_valid` toggled every other cycle: identical memory contents.
- Header 01 04 (N = 1025 > 1024): `load_err` = 1 and `rx_ready` = 0 the cycle after the HDR1 transfer; `core_run` stays 0; no `mem_we`.
- Header 00 00: no writes; `core_run` = 1 the cycle after the HDR1 transfer; `words_loaded` = 0.
- `rst` asserted after 6 data bytes of an N = 3 load:
  - Next cycle: `words_loaded` = 0, `core_run` = 0, `rx_ready` = 1.
  - A fresh N = 1 load then writes word 0 only and runs.
- In RUN with `pc` = 32'h0000_1000 (wraps to word 0): `instr` equals word 0. Bytes offered in RUN: `rx_ready` = 0, no `mem_we`.
